// File: rtl/wb_timer_slave.sv
// wb_timer_slave: Wishbone-mapped 16-bit down-counting timer with interrupt.
//
// Register map (word offsets from BASE_ADR):
//   0 CTRL   : bit0 EN, bit1 AUTO (reload on expiry), bit2 IE
//   1 COUNT  : current count, decremented once per prescaler tick
//   2 RELOAD : value loaded into COUNT on expiry when AUTO=1
//   3 STATUS : bit0 EXP, write 1 to clear
//
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   wb_cyc/stb/we/adr    : Wishbone request
//   wb_dat_i / wb_dat_o  : write / read data
//   wb_ack               : one-cycle acknowledge, one wait state per access
//   irq                  : level interrupt, EXP & IE
module wb_timer_slave #(
  parameter int unsigned PRESCALE = 16,
  parameter logic [15:0] BASE_ADR = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [15:0] wb_adr,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack,
  output logic        irq
);

  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;

  typedef struct packed {
    logic ie;
    logic auto_rl;
    logic en;
  } ctrl_t;

  state_t      state_q, state_d;
  ctrl_t       ctrl_q;
  logic [15:0] count_q, reload_q, psc_q, rd_q, rd_mux;
  logic        exp_q;
  logic        sel, acc, wr, tick;

  // sel is only acted on from IDLE; a strobe still high during ACK is ignored
  assign sel  = wb_cyc & wb_stb & (wb_adr[15:2] == BASE_ADR[15:2]);
  assign acc  = sel & (state_q == S_IDLE);
  assign wr   = acc & wb_we;
  assign tick = ctrl_q.en & (psc_q == PS_LAST);
  assign irq  = exp_q & ctrl_q.ie;

  // ---------------- handshake FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sel) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wb_ack   = 1'b0;
    wb_dat_o = '0;
    if (state_q == S_ACK) begin
      wb_ack   = 1'b1;
      wb_dat_o = rd_q;
    end
  end

  // ---------------- read path ----------------
  always_comb begin
    case (wb_adr[1:0])
      2'd0:    rd_mux = {13'b0, ctrl_q};
      2'd1:    rd_mux = count_q;
      2'd2:    rd_mux = reload_q;
      default: rd_mux = {15'b0, exp_q};
    endcase
  end

  // Read data is captured at acceptance, so a read returns the pre-edge value
  always_ff @(posedge clk) begin
    if (!rst_n)   rd_q <= '0;
    else if (acc) rd_q <= rd_mux;
  end

  // ---------------- timer core ----------------
  // Assignment order encodes priority: W1C < tick set of EXP, and tick
  // updates of COUNT/EN < a CPU write to the same register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_q   <= '0;
      count_q  <= '0;
      reload_q <= '0;
      exp_q    <= 1'b0;
      psc_q    <= '0;
    end else begin
      // held at 0 while disabled, so enabling always starts a fresh period
      if (!ctrl_q.en || tick) psc_q <= '0;
      else                    psc_q <= psc_q + 16'd1;

      if (wr && wb_adr[1:0] == 2'd3 && wb_dat_i[0]) exp_q <= 1'b0;

      if (tick) begin
        if (count_q != 16'd0) begin
          count_q <= count_q - 16'd1;
        end else begin
          exp_q <= 1'b1;
          if (ctrl_q.auto_rl) count_q   <= reload_q;
          else                ctrl_q.en <= 1'b0;
        end
      end

      if (wr) begin
        case (wb_adr[1:0])
          2'd0:    ctrl_q   <= ctrl_t'(wb_dat_i[2:0]);
          2'd1:    count_q  <= wb_dat_i;
          2'd2:    reload_q <= wb_dat_i;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_timer_slave.sv
// Scoreboard bench for wb_timer_slave: the driver predicts each ack (edge and
// read data) from a reference model and queues it; a monitor checks the DUT.
module tb_wb_timer_slave;
  localparam int          P    = 4;
  localparam logic [15:0] BASE = 16'hFF00;

  logic        clk = 1'b0;
  logic        rst_n, wb_cyc, wb_stb, wb_we, wb_ack, irq;
  logic [15:0] wb_adr, wb_dat_i, wb_dat_o;

  wb_timer_slave #(.PRESCALE(P), .BASE_ADR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack(wb_ack), .irq(irq)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_assert = 0, n_fail = 0, n_ack = 0;
  bit mon_on = 1'b0;

  typedef struct {
    int          at;
    bit          cmp;
    logic [15:0] dat;
  } exp_t;
  exp_t sbq[$];

  // Reference model: register contents plus the edge at which EN last rose;
  // ticks fall on every P-th edge after that.
  bit          m_en, m_auto, m_ie, m_exp, m_busy;
  logic [15:0] m_count, m_reload;
  int          m_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic bit tick_at(input int e);
    return m_en && (e > m_s) && ((e - m_s) % P == 0);
  endfunction

  function automatic logic [15:0] m_rd(input logic [1:0] a);
    case (a)
      2'd0:    return {13'b0, m_ie, m_auto, m_en};
      2'd1:    return m_count;
      2'd2:    return m_reload;
      default: return {15'b0, m_exp};
    endcase
  endfunction

  task automatic m_clear();
    m_en = 0; m_auto = 0; m_ie = 0; m_exp = 0; m_busy = 0;
    m_count = '0; m_reload = '0; m_s = 0;
  endtask

  // One clock: drive inputs, predict any ack, then advance the model.
  task automatic cyc_step(input bit c, input bit s, input bit w, input logic [15:0] a,
                          input logic [15:0] d, input bit r,
                          input bit fix = 1'b0, input logic [15:0] fixv = 16'h0);
    int   e;
    bit   acc_m, tk, en0;
    exp_t x;
    wb_cyc = c; wb_stb = s; wb_we = w; wb_adr = a; wb_dat_i = d; rst_n = r;
    e     = edge_n + 1;
    tk    = tick_at(e);
    en0   = m_en;
    acc_m = r && c && s && (a[15:2] == BASE[15:2]) && !m_busy;
    if (acc_m) begin
      x.at = e; x.cmp = !w; x.dat = fix ? fixv : m_rd(a[1:0]);
      sbq.push_back(x);
    end
    @(posedge clk);
    if (!r) begin
      m_clear();
    end else begin
      if (acc_m && w && a[1:0] == 2'd3 && d[0]) m_exp = 1'b0;
      if (tk) begin
        if (m_count != 16'd0) m_count = m_count - 16'd1;
        else begin
          m_exp = 1'b1;
          if (m_auto) m_count = m_reload;
          else        m_en = 1'b0;
        end
      end
      if (acc_m && w) begin
        case (a[1:0])
          2'd0: begin
            if (!en0 && d[0]) m_s = e;
            m_en = d[0]; m_auto = d[1]; m_ie = d[2];
          end
          2'd1:    m_count = d;
          2'd2:    m_reload = d;
          default: ;
        endcase
      end
    end
    m_busy = acc_m;
    #1;
  endtask

  task automatic idle();
    cyc_step(0, 0, 0, 16'h0, 16'h0, 1);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    cyc_step(1, 1, 1, a, d, 1);
    cyc_step(1, 1, 1, a, d, 1);
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] v);
    cyc_step(1, 1, 0, a, 16'h0, 1, 1'b1, v);
    cyc_step(1, 1, 0, a, 16'h0, 1);
  endtask

  // Idle until the coming edge is a prescaler tick.
  task automatic align_tick();
    int k = 0;
    while (!tick_at(edge_n + 1) && k < 3 * P + 4) begin
      idle();
      k++;
    end
    if (!tick_at(edge_n + 1)) begin
      n_assert++; n_fail++;
      $display("FAIL tick_align: no tick within %0d cycles", k);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        chk("irq", 32'(irq), 32'(m_exp & m_ie));
        if (wb_ack === 1'b1) begin
          n_ack++;
          if (sbq.size() == 0) begin
            chk("unexpected_ack", 32'(wb_ack), 32'd0);
          end else begin
            x = sbq.pop_front();
            chk("ack_edge", edge_n, x.at);
            if (x.cmp) chk("rd_data", 32'(wb_dat_o), 32'(x.dat));
          end
        end else begin
          chk("dat_o_idle", 32'(wb_dat_o), 32'd0);
          if (sbq.size() > 0 && sbq[0].at <= edge_n) begin
            chk("missing_ack", 32'(wb_ack), 32'd1);
            void'(sbq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int a0;
    m_clear();
    repeat (3) cyc_step(0, 0, 0, 16'h0, 16'h0, 0);
    mon_on = 1'b1;

    // reset state
    chk("rst_ack", 32'(wb_ack), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    for (int i = 0; i < 4; i++) rd(BASE | 16'(i), 16'h0);

    // RELOAD write/readback
    wr(16'hFF02, 16'h0005);
    rd(16'hFF02, 16'h0005);

    // strobe held 6 cycles -> 3 acks; foreign address -> none
    a0 = n_ack;
    repeat (6) cyc_step(1, 1, 0, 16'hFF01, 16'h0, 1);
    idle();
    chk("hold6_acks", n_ack - a0, 3);
    a0 = n_ack;
    repeat (6) cyc_step(1, 1, 0, 16'hFE00, 16'h0, 1);
    idle();
    chk("foreign_acks", n_ack - a0, 0);

    // one-shot countdown
    wr(16'hFF01, 16'h0002);
    wr(16'hFF00, 16'h0001);
    align_tick(); idle();
    rd(16'hFF01, 16'h0001);
    align_tick(); idle();
    rd(16'hFF01, 16'h0000);
    align_tick(); idle();
    rd(16'hFF03, 16'h0001);
    rd(16'hFF00, 16'h0000);
    chk("oneshot_irq", 32'(irq), 32'd0);

    // auto-reload with interrupt
    wr(16'hFF02, 16'h0003);
    wr(16'hFF01, 16'h0000);
    wr(16'hFF00, 16'h0007);
    align_tick(); idle();
    chk("auto_irq_first", 32'(irq), 32'd1);
    rd(16'hFF03, 16'h0001);
    rd(16'hFF01, 16'h0003);
    wr(16'hFF03, 16'h0001);
    chk("w1c_irq", 32'(irq), 32'd0);
    for (int k = 0; k < 3; k++) begin
      align_tick(); idle();
      chk("auto_irq_again", 32'(irq), (k == 2) ? 32'd1 : 32'd0);
    end
    rd(16'hFF01, 16'h0003);

    // CPU COUNT write on a tick wins; W1C on expiry loses
    wr(16'hFF03, 16'h0001);
    align_tick();
    wr(16'hFF01, 16'h00AA);
    rd(16'hFF01, 16'h00AA);
    align_tick(); idle();
    wr(16'hFF01, 16'h0000);
    align_tick();
    wr(16'hFF03, 16'h0001);
    rd(16'hFF03, 16'h0001);
    rd(16'hFF01, 16'h0003);

    // reset during ACK while running
    align_tick(); idle();
    wr(16'hFF01, 16'h0009);
    wr(16'hFF00, 16'h0001);
    idle();
    cyc_step(1, 1, 0, 16'hFF01, 16'h0, 1);
    cyc_step(0, 0, 0, 16'h0, 16'h0, 0);
    chk("rst_in_ack", 32'(wb_ack), 32'd0);
    cyc_step(0, 0, 0, 16'h0, 16'h0, 0);
    for (int i = 0; i < 4; i++) rd(BASE | 16'(i), 16'h0);

    // randomized traffic against the model
    for (int i = 0; i < 250; i++) begin
      logic [15:0] a, d;
      bit          w;
      a = BASE | 16'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        a = 16'($urandom);
        if (a[15:2] == BASE[15:2]) a[15] = ~a[15];
      end
      w = 1'($urandom_range(0, 1));
      case (a[1:0])
        2'd0:    d = 16'($urandom_range(0, 7));
        2'd1:    d = 16'($urandom_range(0, 10));
        2'd2:    d = 16'($urandom_range(0, 5));
        default: d = 16'($urandom_range(0, 1));
      endcase
      if (w && !a[1] && tick_at(edge_n + 1)) w = 1'b0;
      cyc_step(1, 1, w, a, d, 1);
      cyc_step(1, 1, w, a, d, 1);
      repeat ($urandom_range(0, 3)) idle();
    end

    repeat (3) idle();
    chk("sb_drain", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
